scan_master: RTL and testbench

SCAN_MASTER -- requirements
Module: scan_master

---
 rtl/scan_master_if.sv | 53 +++++
 rtl/scan_master.sv | 211 +++++++++++++++++++++
 tb/tb_scan_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_master_if.sv
// scan_master_if: bundles the host-side transaction handshake and the scan-pad
// signals of scan_master.
//   Host side : start, tx_data, do_load_chip, do_load_chain, [cmd_id] -> master
//               busy, done, rx_data                                  <- master
//   Pad side  : scan_phi, scan_phi_bar, scan_data_in, scan_load_chip,
//               scan_load_chain, scan_id                             <- master
//               scan_data_out                                        -> master
// Optional feature macro: SCAN_MASTER_ID_EN (adds cmd_id).
interface scan_master_if #(
  parameter int unsigned CHAIN_LEN = 64
);
  logic                 start;
  logic [CHAIN_LEN-1:0] tx_data;
  logic                 do_load_chip;
  logic                 do_load_chain;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] rx_data;
  logic                 scan_phi;
  logic                 scan_phi_bar;
  logic                 scan_data_in;
  logic                 scan_data_out;
  logic                 scan_load_chip;
  logic                 scan_load_chain;
  logic                 scan_id;
`ifdef SCAN_MASTER_ID_EN
  logic                 cmd_id;

  modport master (
    input  start, tx_data, do_load_chip, do_load_chain, cmd_id, scan_data_out,
    output busy, done, rx_data, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, scan_load_chain, scan_id
  );

  modport slave (
    output start, tx_data, do_load_chip, do_load_chain, cmd_id, scan_data_out,
    input  busy, done, rx_data, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, scan_load_chain, scan_id
  );
`else
  modport master (
    input  start, tx_data, do_load_chip, do_load_chain, scan_data_out,
    output busy, done, rx_data, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, scan_load_chain, scan_id
  );

  modport slave (
    output start, tx_data, do_load_chip, do_load_chain, scan_data_out,
    input  busy, done, rx_data, scan_phi, scan_phi_bar, scan_data_in,
           scan_load_chip, scan_load_chain, scan_id
  );
`endif
endinterface

// File: rtl/scan_master.sv
// scan_master: shifts a CHAIN_LEN-bit word MSB first into a scan chain using
// two-phase non-overlapping scan clocks, captures the chain's serial output,
// and optionally strobes chip/chain load pulses afterwards.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : scan_master_if.master (host handshake + scan pads)
// Optional feature macro: SCAN_MASTER_ID_EN -- latches cmd_id at accept and
// drives it on scan_id for the whole transaction; otherwise scan_id is 0.
module scan_master #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned PHASE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input logic           clk,
  input logic           rst_n,
  scan_master_if.master bus
);

  localparam int unsigned CNT_MAX = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PHI, S_GAP_A, S_PHIB, S_GAP_B,
    S_LOAD_CHIP, S_GAP_C, S_LOAD_CHAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rxsh_q, rxsh_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic                 ld_chip_q, ld_chip_d;
  logic                 ld_chain_q, ld_chain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 phi_q, phi_d;
  logic                 phib_q, phib_d;
  logic                 din_q, din_d;
  logic                 lchip_q, lchip_d;
  logic                 lchain_q, lchain_d;
  logic                 enter_phi;
`ifdef SCAN_MASTER_ID_EN
  logic                 id_q, id_d;
  logic                 sid_q, sid_d;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    tx_d       = tx_q;
    rxsh_d     = rxsh_q;
    rx_d       = rx_q;
    ld_chip_d  = ld_chip_q;
    ld_chain_d = ld_chain_q;
    din_d      = din_q;
    enter_phi  = 1'b0;
`ifdef SCAN_MASTER_ID_EN
    id_d       = id_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d    = S_PHI;
          tx_d       = bus.tx_data;
          ld_chip_d  = bus.do_load_chip;
          ld_chain_d = bus.do_load_chain;
          bit_d      = '0;
          enter_phi  = 1'b1;
`ifdef SCAN_MASTER_ID_EN
          id_d       = bus.cmd_id;
`endif
        end
      end
      S_PHI: if (cnt_q == PH_LAST) begin
        state_d = S_GAP_A;
        cnt_d   = '0;
      end
      S_GAP_A: if (cnt_q == GAP_LAST) begin
        state_d = S_PHIB;
        cnt_d   = '0;
      end
      S_PHIB: if (cnt_q == PH_LAST) begin
        state_d = S_GAP_B;
        cnt_d   = '0;
      end
      S_GAP_B: if (cnt_q == GAP_LAST) begin
        cnt_d = '0;
        if (bit_q == BIT_LAST) begin
          din_d = 1'b0;
          if (ld_chip_q)       state_d = S_LOAD_CHIP;
          else if (ld_chain_q) state_d = S_LOAD_CHAIN;
          else                 state_d = S_DONE;
        end else begin
          bit_d     = bit_q + BIT_W'(1);
          state_d   = S_PHI;
          enter_phi = 1'b1;
        end
      end
      S_LOAD_CHIP: if (cnt_q == PH_LAST) begin
        state_d = S_GAP_C;
        cnt_d   = '0;
      end
      S_GAP_C: if (cnt_q == GAP_LAST) begin
        state_d = ld_chain_q ? S_LOAD_CHAIN : S_DONE;
        cnt_d   = '0;
      end
      S_LOAD_CHAIN: if (cnt_q == PH_LAST) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Each PHI entry edge presents the next MSB and captures the chain output
    if (enter_phi) begin
      din_d  = tx_d[CHAIN_LEN-1];
      tx_d   = tx_d << 1;
      rxsh_d = CHAIN_LEN'({rxsh_q, bus.scan_data_out});
    end

    // Captured word becomes visible only in the DONE cycle
    if ((state_d == S_DONE) && (state_q != S_DONE)) rx_d = rxsh_q;

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    phi_d    = (state_d == S_PHI);
    phib_d   = (state_d == S_PHIB);
    lchip_d  = (state_d == S_LOAD_CHIP);
    lchain_d = (state_d == S_LOAD_CHAIN);
`ifdef SCAN_MASTER_ID_EN
    sid_d    = id_d & (state_d != S_IDLE);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rxsh_q     <= '0;
      rx_q       <= '0;
      ld_chip_q  <= 1'b0;
      ld_chain_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      phi_q      <= 1'b0;
      phib_q     <= 1'b0;
      din_q      <= 1'b0;
      lchip_q    <= 1'b0;
      lchain_q   <= 1'b0;
`ifdef SCAN_MASTER_ID_EN
      id_q       <= 1'b0;
      sid_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rxsh_q     <= rxsh_d;
      rx_q       <= rx_d;
      ld_chip_q  <= ld_chip_d;
      ld_chain_q <= ld_chain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      phi_q      <= phi_d;
      phib_q     <= phib_d;
      din_q      <= din_d;
      lchip_q    <= lchip_d;
      lchain_q   <= lchain_d;
`ifdef SCAN_MASTER_ID_EN
      id_q       <= id_d;
      sid_q      <= sid_d;
`endif
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.rx_data         = rx_q;
  assign bus.scan_phi        = phi_q;
  assign bus.scan_phi_bar    = phib_q;
  assign bus.scan_data_in    = din_q;
  assign bus.scan_load_chip  = lchip_q;
  assign bus.scan_load_chain = lchain_q;
`ifdef SCAN_MASTER_ID_EN
  assign bus.scan_id         = sid_q;
`else
  assign bus.scan_id         = 1'b0;
`endif

endmodule

// File: tb/tb_scan_master.sv
// tb_scan_master: randomized self-checking bench for scan_master. A timeline
// model derives every output from the transaction's position in its cycle
// budget; an external 8-bit chain model answers on scan_data_out.
module tb_scan_master;
  localparam int N  = 8;
  localparam int P  = 2;
  localparam int G  = 1;
  localparam int BP = 2 * (P + G);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  scan_master_if #(.CHAIN_LEN(N)) bus();

  scan_master #(.CHAIN_LEN(N), .PHASE_CYC(P), .GAP_CYC(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // External scan chain: master latch closes on phi fall, chain shifts on phi_bar rise
  logic [N-1:0] chain;
  logic [N-1:0] pre_val;
  logic         pre_ld = 1'b0;
  logic         master_l;
  always @(negedge bus.scan_phi) master_l = bus.scan_data_in;
  always @(posedge bus.scan_phi_bar or posedge pre_ld)
    if (pre_ld) chain = pre_val;
    else        chain = {chain[N-2:0], master_l};
  assign bus.scan_data_out = chain[N-1];

  // Reference model: rel = cycle index within the current transaction (0 = idle)
  int           rel = 0;
  int           m_len = 0;
  logic [N-1:0] m_tx = '0, m_pre = '0, m_rx = '0;
  bit           m_lc = 0, m_lch = 0, m_id = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel  = 0;
      m_rx = '0;
    end else if (rel == 0) begin
      if (bus.start === 1'b1) begin
        rel   = 1;
        m_tx  = bus.tx_data;
        m_lc  = bus.do_load_chip;
        m_lch = bus.do_load_chain;
        m_pre = chain;
`ifdef SCAN_MASTER_ID_EN
        m_id  = bus.cmd_id;
`else
        m_id  = 1'b0;
`endif
        m_len = N * BP + (m_lc ? P + G : 0) + (m_lch ? P : 0) + 1;
      end
    end else if (rel == m_len) begin
      rel = 0;
    end else begin
      rel++;
      if (rel == m_len) m_rx = m_pre;
    end
  end

  // Per-cycle comparison of every output against the model
  int since_phi = 0;
  bit prev_phib = 0;
  always @(negedge clk) begin
    bit e_phi, e_phib, e_lc, e_lch, e_sh, e_din;
    int k, p, q;
    e_phi = 0; e_phib = 0; e_lc = 0; e_lch = 0; e_sh = 0; e_din = 0;
    if (rel >= 1 && rel <= N * BP) begin
      k      = (rel - 1) / BP;
      p      = (rel - 1) % BP;
      e_phi  = (p < P);
      e_phib = (p >= P + G) && (p < 2 * P + G);
      e_sh   = 1;
      e_din  = m_tx[N-1-k];
    end else if (rel > N * BP && rel < m_len) begin
      q = rel - N * BP;
      if (m_lc) begin
        e_lc = (q <= P);
        q    = q - (P + G);
      end
      e_lch = m_lch && (q >= 1) && (q <= P);
    end
    chk("busy", bus.busy, rel != 0);
    chk("done", bus.done, (rel != 0) && (rel == m_len));
    chk("phi", bus.scan_phi, e_phi);
    chk("phi_bar", bus.scan_phi_bar, e_phib);
    chk("load_chip", bus.scan_load_chip, e_lc);
    chk("load_chain", bus.scan_load_chain, e_lch);
    chk("rx_data", bus.rx_data, m_rx);
    chk("scan_id", bus.scan_id, m_id && (rel != 0));
    if (e_sh) chk("data_in", bus.scan_data_in, e_din);
    chk("phi_overlap", bus.scan_phi & bus.scan_phi_bar, 1'b0);
    if (bus.scan_phi_bar && !prev_phib) chk("phi_gap_ok", since_phi >= G, 1'b1);
    prev_phib = bus.scan_phi_bar;
    if (bus.scan_phi) since_phi = 0;
    else              since_phi++;
  end

  task automatic preload(input logic [N-1:0] v);
    pre_val = v;
    pre_ld  = 1'b1;
    #1 pre_ld = 1'b0;
  endtask

  // One transaction; optional start pokes at cycle poke_at / in DONE, optional reset at rst_at
  task automatic txn(input logic [N-1:0] tx, input bit lc, input bit lch, input bit id,
                     input int poke_at, input bit poke_done, input int rst_at,
                     output int lat, output logic [N-1:0] seq, output int nchip, output int nchain);
    bit prev_phi, fin;
    int w;
    lat = 0; seq = '0; nchip = 0; nchain = 0; w = 0;
    while (bus.busy !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.start         = 1'b1;
    bus.tx_data       = tx;
    bus.do_load_chip  = lc;
    bus.do_load_chain = lch;
`ifdef SCAN_MASTER_ID_EN
    bus.cmd_id        = id;
`endif
    @(negedge clk);
    bus.start         = 1'b0;
    bus.tx_data       = N'($urandom);
    bus.do_load_chip  = ~lc;
    bus.do_load_chain = ~lch;
`ifdef SCAN_MASTER_ID_EN
    bus.cmd_id        = ~id;
`endif
    lat = 1; prev_phi = 0; fin = 0;
    while (!fin) begin
      if (bus.scan_phi && !prev_phi) seq = {seq[N-2:0], bus.scan_data_in};
      prev_phi = bus.scan_phi;
      nchip  += int'(bus.scan_load_chip);
      nchain += int'(bus.scan_load_chain);
      if (bus.done === 1'b1) begin
        fin = 1;
        if (poke_done) bus.start = 1'b1;
      end else if (lat == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_phi", bus.scan_phi, 1'b0);
        chk("rst_phi_bar", bus.scan_phi_bar, 1'b0);
        chk("rst_data_in", bus.scan_data_in, 1'b0);
        chk("rst_load_chip", bus.scan_load_chip, 1'b0);
        chk("rst_load_chain", bus.scan_load_chain, 1'b0);
        chk("rst_scan_id", bus.scan_id, 1'b0);
        chk("rst_rx_data", bus.rx_data, '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lat = -1;
        fin = 1;
      end else if (lat >= 2000) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done after %0d cycles", lat);
        fin = 1;
      end else begin
        bus.start = (lat == poke_at);
        @(negedge clk);
        lat++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int           lat, nchip, nchain, ndone, exp_len;
    logic [N-1:0] seq, tx, pre;
    bit           lc, lch, id;
    bus.start = 1'b0; bus.tx_data = '0; bus.do_load_chip = 1'b0; bus.do_load_chain = 1'b0;
`ifdef SCAN_MASTER_ID_EN
    bus.cmd_id = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rx", bus.rx_data, '0);

    // Shift-only A5 into a chain preloaded with 3C
    preload(8'h3C);
    txn(8'hA5, 0, 0, 1, -1, 0, -1, lat, seq, nchip, nchain);
    chk("lat_shift_only", lat, 49);
    chk("seq_a5", seq, 8'hA5);
    chk("rx_3c", bus.rx_data, 8'h3C);
    chk("chain_a5", chain, 8'hA5);

    // Both loads
    preload(8'h81);
    txn(8'h5A, 1, 1, 0, -1, 0, -1, lat, seq, nchip, nchain);
    chk("lat_both_loads", lat, 54);
    chk("chip_cycles", nchip, 2);
    chk("chain_cycles", nchain, 2);
    chk("rx_81", bus.rx_data, 8'h81);

    // Start pokes at cycle 10 and in DONE are ignored
    txn(8'hC3, 0, 1, 1, 10, 1, -1, lat, seq, nchip, nchain);
    chk("lat_chain_only", lat, 51);
    chk("busy_after_done", bus.busy, 1'b0);
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    chk("no_extra_done", ndone, 0);

    // Reset at cycle 20 aborts, then a fresh FF transaction
    txn(8'h0F, 1, 0, 1, -1, 0, 20, lat, seq, nchip, nchain);
    chk("aborted", lat, -1);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    chk("no_done_after_abort", ndone, 0);
    txn(8'hFF, 0, 0, 0, -1, 0, -1, lat, seq, nchip, nchain);
    chk("seq_ff", seq, 8'hFF);
    chk("lat_ff", lat, 49);

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      tx  = N'($urandom);
      pre = N'($urandom);
      lc  = 1'($urandom);
      lch = 1'($urandom);
      id  = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      preload(pre);
      txn(tx, lc, lch, id, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 45)) : -1,
          1'($urandom), -1, lat, seq, nchip, nchain);
      exp_len = N * BP + (lc ? P + G : 0) + (lch ? P : 0) + 1;
      chk("rand_lat", lat, exp_len);
      chk("rand_seq", seq, tx);
      chk("rand_rx", bus.rx_data, pre);
      chk("rand_chain", chain, tx);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
